// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M sequencer: funct3 encodings, FSM states,
// default divide length and small operand helpers.
package muldiv_seq_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDS_IDLE = 2'd0,
    MDS_MUL  = 2'd1,
    MDS_DIV  = 2'd2,
    MDS_DONE = 2'd3
  } mds_e;

  localparam int MD_DIV_STEPS = 32;

  // Sign- or zero-extend an operand; the low 64 bits of the product of two
  // such values equal those of the 33x33 signed product.
  function automatic logic signed [63:0] mul_ext(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned radix-2 restoring divider: load latches the operands, each step
// performs one shift-subtract. Outputs are the values after the current step.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            ge;

  // Partial remainder stays below the divisor, so bit XLEN of the difference is its sign.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[XLEN];
  assign rem_o   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_o   = {quo_q[XLEN-2:0], ge};

  always_ff @(posedge clk) begin
    if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quo_o;
      rem_q <= rem_o;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer for the EX stage. Optional divide result
// cache enabled by defining MULDIV_REM_FUSE_EN.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = MD_DIV_STEPS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            ex_stall_o
);

  localparam int CW = $clog2(DIV_STEPS + 1);

  mds_e                state_q;
  logic                busy_q;
  logic                done_q;
  logic [XLEN-1:0]     result_q;
  logic [CW-1:0]       cnt_q;

  logic [2:0]          op_q;
  logic                qneg_q;
  logic                rneg_q;
  logic signed [63:0]  mul_a_q;
  logic signed [63:0]  mul_b_q;
  logic signed [63:0]  prod;

  logic                accept;
  logic                op_is_mul;
  logic                op_sgn_div;
  logic                op_is_rem;
  logic                special;
  logic [XLEN-1:0]     special_res;
  logic                fuse_hit;
  logic [XLEN-1:0]     fuse_res;
  logic                div_step;
  logic                div_last;
  logic [XLEN-1:0]     quo_u;
  logic [XLEN-1:0]     rem_u;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     mul_res;
  logic [XLEN-1:0]     div_res;

  assign accept     = start_i & ~kill_i & ((state_q == MDS_IDLE) | (state_q == MDS_DONE));
  assign op_is_mul  = op_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU};
  assign op_sgn_div = (op_i == MD_DIV) | (op_i == MD_REM);
  assign op_is_rem  = (op_i == MD_REM) | (op_i == MD_REMU);

  // Divide by zero and signed overflow resolve at accept without iterating.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (rs2_i == '0) begin
      special     = 1'b1;
      special_res = op_is_rem ? rs1_i : '1;
    end else if (op_sgn_div && rs1_i == 32'h8000_0000 && rs2_i == 32'hFFFF_FFFF) begin
      special     = 1'b1;
      special_res = op_is_rem ? '0 : 32'h8000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_i;
      mul_a_q <= mul_ext(rs1_i, (op_i == MD_MULH) | (op_i == MD_MULHSU));
      mul_b_q <= mul_ext(rs2_i, op_i == MD_MULH);
      qneg_q  <= op_sgn_div & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
      rneg_q  <= op_sgn_div & rs1_i[XLEN-1];
    end
  end

  assign prod    = mul_a_q * mul_b_q;
  assign mul_res = (op_q == MD_MUL) ? prod[31:0] : prod[63:32];

  assign div_step = (state_q == MDS_DIV) & ~kill_i;
  assign div_last = div_step & (cnt_q == CW'(1));

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .load_i     (accept & ~op_is_mul),
    .step_i     (div_step),
    .dividend_i (cond_neg(rs1_i, op_sgn_div & rs1_i[XLEN-1])),
    .divisor_i  (cond_neg(rs2_i, op_sgn_div & rs2_i[XLEN-1])),
    .quo_o      (quo_u),
    .rem_o      (rem_u)
  );

  assign quo_fix = cond_neg(quo_u, qneg_q);
  assign rem_fix = cond_neg(rem_u, rneg_q);
  assign div_res = op_q[1] ? rem_fix : quo_fix;

`ifdef MULDIV_REM_FUSE_EN
  logic            fc_vld_q;
  logic [XLEN-1:0] fc_a_q;
  logic [XLEN-1:0] fc_b_q;
  logic            fc_sgn_q;
  logic [XLEN-1:0] fc_quo_q;
  logic [XLEN-1:0] fc_rem_q;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] opb_q;
  logic            sgn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_vld_q <= 1'b0;
    end else if ((accept & op_is_mul) | ((state_q == MDS_DIV) & kill_i)) begin
      fc_vld_q <= 1'b0;
    end else if (div_last) begin
      fc_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      opa_q <= rs1_i;
      opb_q <= rs2_i;
      sgn_q <= op_sgn_div;
    end
    if (div_last) begin
      fc_a_q   <= opa_q;
      fc_b_q   <= opb_q;
      fc_sgn_q <= sgn_q;
      fc_quo_q <= quo_fix;
      fc_rem_q <= rem_fix;
    end
  end

  assign fuse_hit = fc_vld_q & (rs1_i == fc_a_q) & (rs2_i == fc_b_q) & (op_sgn_div == fc_sgn_q);
  assign fuse_res = op_is_rem ? fc_rem_q : fc_quo_q;
`else
  assign fuse_hit = 1'b0;
  assign fuse_res = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDS_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MDS_IDLE, MDS_DONE: begin
          if (!accept) begin
            state_q <= MDS_IDLE;
            busy_q  <= 1'b0;
          end else if (op_is_mul) begin
            state_q <= MDS_MUL;
            busy_q  <= 1'b1;
          end else if (special | fuse_hit) begin
            state_q  <= MDS_DONE;
            done_q   <= 1'b1;
            result_q <= special ? special_res : fuse_res;
          end else begin
            state_q <= MDS_DIV;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(DIV_STEPS);
          end
        end
        MDS_MUL: begin
          busy_q <= 1'b0;
          if (kill_i) begin
            state_q <= MDS_IDLE;
          end else begin
            state_q  <= MDS_DONE;
            done_q   <= 1'b1;
            result_q <= mul_res;
          end
        end
        MDS_DIV: begin
          if (kill_i) begin
            state_q <= MDS_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
            if (div_last) begin
              state_q  <= MDS_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= div_res;
            end
          end
        end
        default: begin
          state_q <= MDS_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign ex_stall_o = (start_i & ~kill_i & ~done_q) | busy_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: a latency/arithmetic model checked every cycle plus
// directed vectors with literal results and completion cycles.
module tb_muldiv_seq;

`ifdef MULDIV_REM_FUSE_EN
  localparam bit FUSE = 1'b1;
`else
  localparam bit FUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        kill_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        ex_stall_o;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .kill_i     (kill_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .ex_stall_o (ex_stall_o)
  );

  always #5 clk = ~clk;

  // Architectural result of an M instruction, straight from the ISA rules.
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, pp;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin pa = {32'd0, a}; pb = {32'd0, b}; pp = pa * pb; return pp[31:0]; end
      3'd1: begin pa = {{32{a[31]}}, a}; pb = {{32{b[31]}}, b}; pp = pa * pb; return pp[63:32]; end
      3'd2: begin pa = {{32{a[31]}}, a}; pb = {32'd0, b}; pp = pa * pb; return pp[63:32]; end
      3'd3: begin pa = {32'd0, a}; pb = {32'd0, b}; pp = pa * pb; return pp[63:32]; end
      default: begin
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? (a % b) : (a / b);
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Model: remaining busy cycles, pending result and the divide result cache.
  int          m_left;
  logic        m_done;
  logic [31:0] m_res, m_pend;
  bit          m_isdiv;
  bit          c_vld, c_sgn, p_sgn;
  logic [31:0] c_a, c_b, p_a, p_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      c_vld  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (kill_i) begin
          m_left <= 0;
          if (m_isdiv) c_vld <= 1'b0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_done <= 1'b1;
            m_res  <= m_pend;
            if (m_isdiv) begin
              c_vld <= 1'b1; c_a <= p_a; c_b <= p_b; c_sgn <= p_sgn;
            end
          end
        end
      end else if (start_i && !kill_i) begin
        if (!op_i[2]) begin
          m_left  <= 1;
          m_pend  <= model_res(op_i, rs1_i, rs2_i);
          m_isdiv <= 1'b0;
          c_vld   <= 1'b0;
        end else if (is_special(op_i, rs1_i, rs2_i) ||
                     (FUSE && c_vld && c_a == rs1_i && c_b == rs2_i && c_sgn == !op_i[0])) begin
          m_done <= 1'b1;
          m_res  <= model_res(op_i, rs1_i, rs2_i);
        end else begin
          m_left  <= 32;
          m_pend  <= model_res(op_i, rs1_i, rs2_i);
          m_isdiv <= 1'b1;
          p_a <= rs1_i; p_b <= rs2_i; p_sgn <= !op_i[0];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("busy_o", 32'(busy_o), 32'(m_left != 0));
    chk("done_o", 32'(done_o), 32'(m_done));
    chk("result_o", result_o, m_res);
    chk("ex_stall_o", 32'(ex_stall_o), 32'((start_i & ~kill_i & ~m_done) | (m_left != 0)));
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  // Issue one op, return at the negedge of the cycle where done_o is seen.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_val, input int exp_lat);
    int n;
    bit saw_busy;
    op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    n = 1;
    saw_busy = busy_o;
    while (!done_o && n < 80) begin
      cycle();
      n++;
      if (!done_o) saw_busy |= busy_o;
    end
    chk({name, " cycle"}, n, exp_lat);
    chk({name, " value"}, result_o, exp_val);
    if (exp_lat == 1) chk({name, " busy seen"}, 32'(saw_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    repeat (3) cycle();
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    rst_n = 1'b1;
    cycle();

    run_op("mulh -2*3",     3'd1, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 2);
    run_op("mul 2^16*2^16", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0,      2);
    run_op("mulhu 2^16*2^16", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1,    2);
    run_op("mulhsu -1*2",   3'd2, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFF, 2);
    run_op("div -7/2",      3'd4, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 33);
    run_op("rem -7/2",      3'd6, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, FUSE ? 1 : 33);
    run_op("divu 100/7",    3'd5, 32'd100,       32'd7,       32'd14,        33);
    run_op("remu 100/7",    3'd7, 32'd100,       32'd7,       32'd2,         FUSE ? 1 : 33);
    run_op("div 7/-2",      3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("divu 5/0",      3'd5, 32'd5,         32'd0,       32'hFFFF_FFFF, 1);
    run_op("rem 5/0",       3'd6, 32'd5,         32'd0,       32'd5,         1);
    run_op("div ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       1);

    // Abort a divide at cycle 10.
    op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    repeat (9) cycle();
    kill_i = 1'b1;
    cycle();
    kill_i = 1'b0;
    chk("kill busy", 32'(busy_o), 32'd0);
    seen = 1'b0;
    repeat (40) begin cycle(); seen |= done_o; end
    chk("kill no done", 32'(seen), 32'd0);
    chk("kill result kept", result_o, 32'd0);
    run_op("divu 9/3", 3'd5, 32'd9, 32'd3, 32'd3, 33);

    // start together with kill: nothing accepted, no stall.
    op_i = 3'd5; rs1_i = 32'd8; rs2_i = 32'd2; start_i = 1'b1; kill_i = 1'b1;
    #1;
    chk("start+kill stall", 32'(ex_stall_o), 32'd0);
    cycle();
    start_i = 1'b0; kill_i = 1'b0;
    chk("start+kill busy", 32'(busy_o), 32'd0);
    chk("start+kill done", 32'(done_o), 32'd0);
    repeat (3) cycle();

    // A second start while busy is ignored.
    op_i = 3'd5; rs1_i = 32'd50; rs2_i = 32'd5; start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    repeat (3) cycle();
    op_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd3; start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    n = 5;
    while (!done_o && n < 80) begin cycle(); n++; end
    chk("busy start cycle", n, 32'd33);
    chk("busy start value", result_o, 32'd10);
    repeat (2) cycle();

    // Cache behaviour around an intervening multiply.
    run_op("div 100/7",  3'd4, 32'd100, 32'd7, 32'd14, 33);
    run_op("rem 100/7",  3'd6, 32'd100, 32'd7, 32'd2,  FUSE ? 1 : 33);
    run_op("mul 3*4",    3'd0, 32'd3,   32'd4, 32'd12, 2);
    run_op("rem 100/7 after mul", 3'd6, 32'd100, 32'd7, 32'd2, 33);

    // Asynchronous reset in the middle of a divide.
    op_i = 3'd5; rs1_i = 32'd77; rs2_i = 32'd7; start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    repeat (4) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy_o), 32'd0);
    chk("async rst done", 32'(done_o), 32'd0);
    chk("async rst result", result_o, 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (35) begin cycle(); seen |= done_o; end
    chk("no done after rst", 32'(seen), 32'd0);
    run_op("mul 7*6", 3'd0, 32'd7, 32'd6, 32'd42, 2);
    run_op("rem -7/2 again", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    repeat (2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
